// File: rtl/if_id_stage.sv
// Instruction fetch with PC, req/valid imem handshake, one-entry skid buffer and
// the IF/ID pipeline register feeding decode.
//
// state | meaning
// FETCH | imem_req high, fetching at pc; transfers go to ID (or skid if stalled)
// HOLD  | skid holds a fetched word waiting for ID to accept it; no fetch
module if_id_stage #(
  parameter int                    DATA_WIDTH = 32,
  parameter logic [DATA_WIDTH-1:0] RESET_PC   = '0
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
  input  logic                      i_stall,
  input  logic                      i_redirect,
  input  logic [DATA_WIDTH-1:0]     i_redirect_target,
  output logic                      o_imem_req,
  output logic [DATA_WIDTH-1:0]     o_imem_addr,
  input  logic                      i_imem_valid,
  input  logic [DATA_WIDTH-1:0]     i_imem_rdata,
  output logic                      o_id_valid,
  output logic [DATA_WIDTH-1:0]     o_id_pc,
  output logic [DATA_WIDTH-1:0]     o_id_pc_plus4,
  output logic [DATA_WIDTH-1:0]     o_id_instr,
  output logic [5:0]                o_id_opcode,
  output logic [4:0]                o_id_rs,
  output logic [4:0]                o_id_rt,
  output logic [4:0]                o_id_rd,
  output logic [5:0]                o_id_funct,
  output logic [DATA_WIDTH/2-1:0]   o_id_imm
);

  typedef enum logic {ST_FETCH = 1'b0, ST_HOLD = 1'b1} state_t;

  localparam logic [DATA_WIDTH-1:0] PC_STEP = DATA_WIDTH'(4);

  state_t                r_state;
  logic                  r_req;
  logic [DATA_WIDTH-1:0] r_pc;
  logic [DATA_WIDTH-1:0] r_skid_instr;
  logic [DATA_WIDTH-1:0] r_skid_pc;
  logic                  r_id_valid;
  logic [DATA_WIDTH-1:0] r_id_instr;
  logic [DATA_WIDTH-1:0] r_id_pc;

  logic w_xfer;
  logic w_unused_tgt_lsb;

  assign w_xfer           = r_req && i_imem_valid;
  assign w_unused_tgt_lsb = ^i_redirect_target[1:0];

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state      <= ST_FETCH;
      r_req        <= 1'b1;
      r_pc         <= RESET_PC;
      r_skid_instr <= '0;
      r_skid_pc    <= '0;
      r_id_valid   <= 1'b0;
      r_id_instr   <= '0;
      r_id_pc      <= '0;
    end else if (i_redirect) begin
      // Any same-cycle transfer belongs to the wrong path and is dropped.
      r_state    <= ST_FETCH;
      r_req      <= 1'b1;
      r_pc       <= {i_redirect_target[DATA_WIDTH-1:2], 2'b00};
      r_id_valid <= 1'b0;
    end else begin
      case (r_state)
        ST_FETCH: begin
          if (w_xfer) begin
            r_pc <= r_pc + PC_STEP;
            if (i_stall) begin
              r_skid_instr <= i_imem_rdata;
              r_skid_pc    <= r_pc;
              r_state      <= ST_HOLD;
              r_req        <= 1'b0;
            end else begin
              r_id_instr <= i_imem_rdata;
              r_id_pc    <= r_pc;
              r_id_valid <= 1'b1;
            end
          end else if (!i_stall) begin
            r_id_valid <= 1'b0;
          end
        end
        ST_HOLD: begin
          if (!i_stall) begin
            r_id_instr <= r_skid_instr;
            r_id_pc    <= r_skid_pc;
            r_id_valid <= 1'b1;
            r_state    <= ST_FETCH;
            r_req      <= 1'b1;
          end
        end
        default: begin
          r_state <= ST_FETCH;
          r_req   <= 1'b1;
        end
      endcase
    end
  end

  // Request is forced low while reset is asserted even though the state is FETCH.
  assign o_imem_req    = r_req && !i_rst;
  assign o_imem_addr   = r_pc;
  assign o_id_valid    = r_id_valid;
  assign o_id_pc       = r_id_pc;
  assign o_id_pc_plus4 = r_id_pc + PC_STEP;
  assign o_id_instr    = r_id_instr;
  assign o_id_opcode   = r_id_instr[31:26];
  assign o_id_rs       = r_id_instr[25:21];
  assign o_id_rt       = r_id_instr[20:16];
  assign o_id_rd       = r_id_instr[15:11];
  assign o_id_funct    = r_id_instr[5:0];
  assign o_id_imm      = r_id_instr[DATA_WIDTH/2-1:0];

endmodule

// File: tb/tb_if_id_stage.sv
// Directed bench for if_id_stage: a behavioural fetch/skid model checked every
// cycle, plus hand-computed literal expectations along the directed sequence.
module tb_if_id_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall, redirect, imem_valid;
  logic [31:0] redirect_target;
  logic        imem_req;
  logic [31:0] imem_addr, imem_rdata;
  logic        id_valid;
  logic [31:0] id_pc, id_pc_plus4, id_instr;
  logic [5:0]  id_opcode, id_funct;
  logic [4:0]  id_rs, id_rt, id_rd;
  logic [15:0] id_imm;

  int total = 0;
  int bad   = 0;

  if_id_stage #(.DATA_WIDTH(32), .RESET_PC(32'h0)) dut (
    .i_clk(clk), .i_rst(rst), .i_stall(stall), .i_redirect(redirect),
    .i_redirect_target(redirect_target), .o_imem_req(imem_req),
    .o_imem_addr(imem_addr), .i_imem_valid(imem_valid), .i_imem_rdata(imem_rdata),
    .o_id_valid(id_valid), .o_id_pc(id_pc), .o_id_pc_plus4(id_pc_plus4),
    .o_id_instr(id_instr), .o_id_opcode(id_opcode), .o_id_rs(id_rs),
    .o_id_rt(id_rt), .o_id_rd(id_rd), .o_id_funct(id_funct), .o_id_imm(id_imm)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h10) return 32'h2008_8000;
    return a ^ 32'hA5A5_0000;
  endfunction

  assign imem_rdata = mem_word(imem_addr);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: where fetch is pointing, whether a word is parked, and what ID shows.
  logic [31:0] m_pc = 32'h0, m_id_pc = 32'h0, m_id_instr = 32'h0;
  logic [31:0] m_park_pc = 32'h0, m_park_instr = 32'h0;
  logic        m_parked = 1'b0, m_id_valid = 1'b0;

  initial begin
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        m_pc = 32'h0; m_parked = 1'b0;
        m_id_valid = 1'b0; m_id_instr = 32'h0; m_id_pc = 32'h0;
      end else if (redirect) begin
        m_pc = redirect_target & ~32'h3;
        m_parked = 1'b0; m_id_valid = 1'b0;
      end else if (m_parked) begin
        if (!stall) begin
          m_id_pc = m_park_pc; m_id_instr = m_park_instr; m_id_valid = 1'b1;
          m_parked = 1'b0;
        end
      end else if (imem_valid) begin
        if (stall) begin
          m_park_pc = m_pc; m_park_instr = mem_word(m_pc); m_parked = 1'b1;
        end else begin
          m_id_pc = m_pc; m_id_instr = mem_word(m_pc); m_id_valid = 1'b1;
        end
        m_pc = m_pc + 32'd4;
      end else if (!stall) begin
        m_id_valid = 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    chk("req",     {31'b0, imem_req},   {31'b0, !rst && !m_parked});
    chk("addr",    imem_addr,            m_pc);
    chk("valid",   {31'b0, id_valid},   {31'b0, m_id_valid});
    chk("instr",   id_instr,             m_id_instr);
    chk("pc",      id_pc,                m_id_pc);
    chk("pc4",     id_pc_plus4,          m_id_pc + 32'd4);
    chk("opcode",  {26'b0, id_opcode},   (m_id_instr >> 26) & 32'h3F);
    chk("rs",      {27'b0, id_rs},       (m_id_instr >> 21) & 32'h1F);
    chk("rt",      {27'b0, id_rt},       (m_id_instr >> 16) & 32'h1F);
    chk("rd",      {27'b0, id_rd},       (m_id_instr >> 11) & 32'h1F);
    chk("funct",   {26'b0, id_funct},    m_id_instr & 32'h3F);
    chk("imm",     {16'b0, id_imm},      m_id_instr & 32'hFFFF);
  end

  task automatic step(input logic st, input logic rd, input logic [31:0] tg, input logic v);
    stall = st; redirect = rd; redirect_target = tg; imem_valid = v;
    @(posedge clk);
    #1;
  endtask

  task automatic lit_id(input string name, input logic v, input logic [31:0] pc,
                        input logic [31:0] addr, input logic req);
    chk({name, "_valid"}, {31'b0, id_valid}, {31'b0, v});
    chk({name, "_pc"},    id_pc,             pc);
    chk({name, "_addr"},  imem_addr,         addr);
    chk({name, "_req"},   {31'b0, imem_req}, {31'b0, req});
  endtask

  initial begin
    rst = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_target = 32'h0; imem_valid = 1'b0;
    #7;
    chk("rst_valid", {31'b0, id_valid}, 32'h0);
    chk("rst_instr", id_instr, 32'h0);
    chk("rst_pc4",   id_pc_plus4, 32'h4);
    chk("rst_req",   {31'b0, imem_req}, 32'h0);
    #5 rst = 1'b0;

    // zero-wait streaming
    step(0, 0, 0, 1); lit_id("s0", 1, 32'h0, 32'h4, 1);
    chk("s0_instr", id_instr, 32'hA5A5_0000);
    chk("s0_pc4", id_pc_plus4, 32'h4);
    step(0, 0, 0, 1); lit_id("s1", 1, 32'h4, 32'h8, 1);
    step(0, 0, 0, 1); lit_id("s2", 1, 32'h8, 32'hC, 1);
    step(0, 0, 0, 1); lit_id("s3", 1, 32'hC, 32'h10, 1);

    // stall on the 0x10 transfer, held 3 cycles
    step(1, 0, 0, 1); lit_id("h0", 1, 32'hC, 32'h14, 0);
    step(1, 0, 0, 1); lit_id("h1", 1, 32'hC, 32'h14, 0);
    step(1, 0, 0, 1); lit_id("h2", 1, 32'hC, 32'h14, 0);
    step(0, 0, 0, 1); lit_id("hr", 1, 32'h10, 32'h14, 1);
    chk("hr_instr", id_instr, 32'h2008_8000);
    chk("hr_imm", {16'b0, id_imm}, 32'h8000);
    chk("hr_rt", {27'b0, id_rt}, 32'h8);
    chk("hr_op", {26'b0, id_opcode}, 32'h8);
    step(0, 0, 0, 1); lit_id("hn", 1, 32'h14, 32'h18, 1);

    // redirect while parked in HOLD with stall high
    step(1, 0, 0, 1); lit_id("p0", 1, 32'h14, 32'h1C, 0);
    step(1, 1, 32'h40, 0); lit_id("p1", 0, 32'h14, 32'h40, 1);
    step(0, 0, 0, 1); lit_id("p2", 1, 32'h40, 32'h44, 1);
    chk("p2_instr", id_instr, 32'hA5A5_0040);

    // redirect coincident with a transfer drops it; target LSBs are cleared
    step(0, 1, 32'h20, 1); lit_id("r0", 0, 32'h40, 32'h20, 1);
    step(0, 1, 32'h103, 1); lit_id("r1", 0, 32'h40, 32'h100, 1);
    step(0, 0, 0, 1); lit_id("r2", 1, 32'h100, 32'h104, 1);

    // two wait states on address 8
    step(0, 1, 32'h8, 0); lit_id("w0", 0, 32'h100, 32'h8, 1);
    step(0, 0, 0, 0); lit_id("w1", 0, 32'h100, 32'h8, 1);
    step(0, 0, 0, 0); lit_id("w2", 0, 32'h100, 32'h8, 1);
    step(0, 0, 0, 1); lit_id("w3", 1, 32'h8, 32'hC, 1);
    step(0, 0, 0, 1); lit_id("w4", 1, 32'hC, 32'h10, 1);

    // pc wrap
    step(0, 1, 32'hFFFF_FFFC, 0); lit_id("x0", 0, 32'hC, 32'hFFFF_FFFC, 1);
    step(0, 0, 0, 1); lit_id("x1", 1, 32'hFFFF_FFFC, 32'h0, 1);
    chk("x1_pc4", id_pc_plus4, 32'h0);

    // async reset in the middle of HOLD
    step(1, 0, 0, 1); lit_id("a0", 1, 32'hFFFF_FFFC, 32'h4, 0);
    #2 rst = 1'b1;
    #1;
    lit_id("a1", 0, 32'h0, 32'h0, 0);
    chk("a1_instr", id_instr, 32'h0);
    chk("a1_pc4", id_pc_plus4, 32'h4);
    stall = 1'b0; imem_valid = 1'b1;
    @(posedge clk);
    #2 rst = 1'b0;
    step(0, 0, 0, 1); lit_id("a2", 1, 32'h0, 32'h4, 1);
    chk("a2_instr", id_instr, 32'hA5A5_0000);

    @(negedge clk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/if_id_stage.md
Name: if_id_stage

Overview:
- Instruction-fetch and IF/ID pipeline register for the 32-bit MIPS datapath.
- Holds the PC and fetches from instruction memory through a req/valid handshake, with a one-entry skid buffer to absorb decode stalls.
- Presents the registered instruction and its decoded fields to the ID stage; id_imm drives the 16-bit input of the sign/zero-extend unit.

Parameters:
- DATA_WIDTH, 32, instruction/PC width (only 32 supported).
- RESET_PC, 32'h0000_0000, PC value after reset (word-aligned).

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- stall  input  1  ID stage cannot accept a new instruction this cycle.
- redirect  input  1  taken branch/jump; load redirect_target.
- redirect_target  input  DATA_WIDTH  new PC.
- imem_req  output  1  fetch request.
- imem_addr  output  DATA_WIDTH  fetch address (= pc).
- imem_valid  input  1  imem_rdata valid for the imem_addr of this cycle.
- imem_rdata  input  DATA_WIDTH  instruction word.
- id_valid  output  1  ID register holds a real instruction.
- id_pc  output  DATA_WIDTH  address of the ID instruction.
- id_pc_plus4  output  DATA_WIDTH  id_pc + 4.
- id_instr  output  DATA_WIDTH  instruction word.
- id_opcode  output  6  id_instr[31:26].
- id_rs  output  5  id_instr[25:21].
- id_rt  output  5  id_instr[20:16].
- id_rd  output  5  id_instr[15:11].
- id_funct  output  6  id_instr[5:0].
- id_imm  output  DATA_WIDTH/2  id_instr[15:0]; goes to the extend unit.

Behaviour:
- Reset (async, while rst=1):
  - pc=RESET_PC; state=FETCH; skid empty.
  - id_valid=0, id_instr=0 (NOP), id_pc=0, id_pc_plus4=4.
  - imem_req=0 while rst is high.
- Transfer: occurs in a cycle where imem_req && imem_valid; data belongs to that cycle's imem_addr.
  - The memory may hold imem_valid low for any number of wait cycles.
  - imem_addr may change between cycles without a transfer.
- State FETCH: imem_req=1, imem_addr=pc.
  - Transfer && !stall: ID reg <= {imem_rdata, pc}, id_valid<=1, pc<=pc+4.
  - Transfer && stall: skid <= {imem_rdata, pc}, pc<=pc+4, go HOLD; ID reg unchanged.
  - No transfer && !stall: id_valid<=0 (bubble); id_instr/id_pc keep their old values.
  - No transfer && stall: ID reg unchanged.
- State HOLD: imem_req=0.
  - !stall: ID reg <= skid, id_valid<=1, skid emptied, go FETCH (fetch at pc next cycle).
  - stall: everything holds.
- Redirect (priority over stall and transfer):
  - pc <= {redirect_target[31:2], 2'b00}.
  - id_valid<=0, skid emptied, state<=FETCH.
  - Any transfer in the same cycle is discarded.
  - Redirect during stall still clears id_valid.
- Priority: rst > redirect > stall > transfer.
- Latency: an instruction transferred in cycle N appears on the id_* outputs after edge N (visible in cycle N+1) when not stalled.
- Throughput: 1 instruction/cycle with a zero-wait memory and no stall.
- Arithmetic: pc increment is modulo 2^32; 32'hFFFF_FFFC wraps to 0.
- The decoded fields are pure slices of id_instr; there is no combinational path from imem_rdata to id_*.
- The skid holds at most one entry; no transfer is possible in HOLD, so the skid never overflows.

Test Plan:
- Reset, RESET_PC=0, zero-wait memory returning addr-tagged words, stall=0 for 4 cycles -> id_pc sequence 0,4,8,C with id_valid=1 each cycle; id_pc_plus4 = id_pc+4.
- Memory inserts 2 wait cycles on address 8 -> two id_valid=0 bubbles, then id_pc=8; pc never skips or duplicates.
- Stall asserted in the cycle a transfer occurs at 0x10 (instr 0x2008_8000), held 3 cycles -> ID holds the previous instruction and imem_req=0 during HOLD; on release id_instr=0x2008_8000, id_imm=16'h8000, id_rt=8, id_opcode=6'h08; next fetch is at 0x14.
- Redirect to 0x40 while in HOLD with stall=1 -> skid discarded, id_valid=0; next transfer is at 0x40; the old skid instruction never appears.
- Redirect to 0x103 in the same cycle as a transfer at 0x20 -> the 0x20 word is dropped and the next imem_addr=0x100.
- Assert rst mid-HOLD -> outputs go to their reset values immediately (async); after release, fetch resumes at RESET_PC. Also: pc=0xFFFF_FFFC transfer -> next imem_addr=0.
